// File: rtl/fp2_res_streamer_pkg.sv
// +----------------------------------------------------------------------------+
// | fp2_res_streamer_pkg : shared sizing helpers, FSM encoding, select codes   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package fp2_res_streamer_pkg;

    localparam logic SEL_SUB = 1'b0;
    localparam logic SEL_ADD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Digit count padded up to a whole number of two-digit memory entries.
    function automatic int calc_width(input int width_real);
        return ((width_real + 1) / 2) * 2;
    endfunction

    function automatic int calc_depth(input int width_real);
        return calc_width(width_real) / 2;
    endfunction

    function automatic int calc_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp2_res_streamer_if.sv
// +----------------------------------------------------------------------------+
// | fp2_res_streamer_if : result-memory read ports plus the digit stream       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface fp2_res_streamer_if #(
    parameter int RADIX  = 32,
    parameter int ADDR_W = 3
);
    logic                  sub_mult_mem_res_rd_en;
    logic [ADDR_W-1:0]     sub_mult_mem_res_rd_addr;
    logic [2*RADIX-1:0]    sub_mult_mem_res_dout;
    logic                  add_mult_mem_res_rd_en;
    logic [ADDR_W-1:0]     add_mult_mem_res_rd_addr;
    logic [2*RADIX-1:0]    add_mult_mem_res_dout;
    logic                  digit_valid;
    logic                  digit_ready;
    logic [RADIX-1:0]      digit_data;
    logic                  digit_last;

    modport master (
        output sub_mult_mem_res_rd_en, sub_mult_mem_res_rd_addr,
        input  sub_mult_mem_res_dout,
        output add_mult_mem_res_rd_en, add_mult_mem_res_rd_addr,
        input  add_mult_mem_res_dout,
        output digit_valid, digit_data, digit_last,
        input  digit_ready
    );

    modport slave (
        input  sub_mult_mem_res_rd_en, sub_mult_mem_res_rd_addr,
        output sub_mult_mem_res_dout,
        input  add_mult_mem_res_rd_en, add_mult_mem_res_rd_addr,
        output add_mult_mem_res_dout,
        input  digit_valid, digit_data, digit_last,
        output digit_ready
    );
endinterface

`default_nettype wire

// File: rtl/fp2_res_streamer_skid.sv
// +----------------------------------------------------------------------------+
// | fp2_res_streamer_skid : hold + prefetch entry registers, digit unpacking   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fp2_res_streamer_skid #(
    parameter int RADIX = 32,
    parameter bit ODD   = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    input  logic [2*RADIX-1:0] in_data_i,
    input  logic               in_last_i,
    output logic               space_o,
    output logic               digit_valid_o,
    input  logic               digit_ready_i,
    output logic [RADIX-1:0]   digit_data_o,
    output logic               digit_last_o
);
    logic [2*RADIX-1:0] hold_q, hold_d, pf_q, pf_d;
    logic hold_vld_q, hold_vld_d, hold_lo_q, hold_lo_d, hold_last_q, hold_last_d;
    logic pf_vld_q, pf_vld_d, pf_last_q, pf_last_d;
    logic w_pop, w_entry_done;

    assign w_pop = hold_vld_q & digit_ready_i;
    // The padding low half of an odd-length final entry is skipped.
    assign w_entry_done = w_pop & (hold_lo_q | (hold_last_q & ODD));

    always_comb begin
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        hold_lo_d   = hold_lo_q;
        hold_last_d = hold_last_q;
        pf_d        = pf_q;
        pf_vld_d    = pf_vld_q;
        pf_last_d   = pf_last_q;
        if (w_pop && !w_entry_done) begin
            hold_lo_d = 1'b1;
        end
        if (w_entry_done) begin
            hold_lo_d = 1'b0;
            if (pf_vld_q) begin
                hold_d      = pf_q;
                hold_last_d = pf_last_q;
                hold_vld_d  = 1'b1;
                pf_vld_d    = in_valid_i;
                pf_d        = in_data_i;
                pf_last_d   = in_last_i;
            end else if (in_valid_i) begin
                hold_d      = in_data_i;
                hold_last_d = in_last_i;
                hold_vld_d  = 1'b1;
            end else begin
                hold_vld_d  = 1'b0;
            end
        end else if (in_valid_i) begin
            if (!hold_vld_q) begin
                hold_d      = in_data_i;
                hold_last_d = in_last_i;
                hold_vld_d  = 1'b1;
                hold_lo_d   = 1'b0;
            end else begin
                pf_d        = in_data_i;
                pf_last_d   = in_last_i;
                pf_vld_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            hold_lo_q   <= 1'b0;
            hold_last_q <= 1'b0;
            pf_q        <= '0;
            pf_vld_q    <= 1'b0;
            pf_last_q   <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            hold_lo_q   <= hold_lo_d;
            hold_last_q <= hold_last_d;
            pf_q        <= pf_d;
            pf_vld_q    <= pf_vld_d;
            pf_last_q   <= pf_last_d;
        end
    end

    assign space_o       = ~pf_vld_q;
    assign digit_valid_o = hold_vld_q;
    assign digit_data_o  = hold_lo_q ? hold_q[RADIX-1:0] : hold_q[2*RADIX-1:RADIX];
    assign digit_last_o  = hold_vld_q & hold_last_q & (hold_lo_q | ODD);

endmodule

`default_nettype wire

// File: rtl/fp2_res_streamer.sv
// +----------------------------------------------------------------------------+
// | fp2_res_streamer : streams one Fp2 result memory as RADIX-bit digits       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fp2_res_streamer
    import fp2_res_streamer_pkg::*;
#(
    parameter int RADIX      = 32,
    parameter int WIDTH_REAL = 14
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic sel_i,
    output logic busy_o,
    output logic done_o,
    fp2_res_streamer_if.master bus
);
    localparam int WIDTH             = calc_width(WIDTH_REAL);
    localparam int RES_MEM_DEPTH     = calc_depth(WIDTH_REAL);
    localparam int RES_MEM_DEPTH_LOG = calc_addr_w(RES_MEM_DEPTH);
    localparam bit ODD               = (WIDTH != WIDTH_REAL);

    state_e                       state_q, state_d;
    logic                         sel_q, sel_d;
    logic [RES_MEM_DEPTH_LOG-1:0] addr_q, addr_d;
    logic                         issued_all_q, issued_all_d;
    logic                         inflight_q, inflight_d;
    logic                         inflight_last_q, inflight_last_d;
    logic                         rd_en;
    logic                         w_space, w_valid, w_last;
    logic [RADIX-1:0]             w_data;

    always_comb begin
        state_d         = state_q;
        sel_d           = sel_q;
        addr_d          = addr_q;
        issued_all_d    = issued_all_q;
        inflight_last_d = inflight_last_q;
        rd_en           = 1'b0;
        busy_o          = 1'b0;
        done_o          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    sel_d        = sel_i;
                    addr_d       = '0;
                    issued_all_d = 1'b0;
                    state_d      = ST_FETCH;
                end
            end
            ST_FETCH: begin
                busy_o  = 1'b1;
                rd_en   = 1'b1;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                busy_o = 1'b1;
                // One entry may be in flight at a time, and only into a free prefetch slot.
                rd_en  = ~issued_all_q & ~inflight_q & w_space;
                if (w_valid && bus.digit_ready && w_last) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
        if (rd_en) begin
            inflight_last_d = (addr_q == RES_MEM_DEPTH_LOG'(RES_MEM_DEPTH - 1));
            if (inflight_last_d) begin
                issued_all_d = 1'b1;
            end else begin
                addr_d = addr_q + RES_MEM_DEPTH_LOG'(1);
            end
        end
        inflight_d = rd_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            sel_q           <= SEL_SUB;
            addr_q          <= '0;
            issued_all_q    <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            sel_q           <= sel_d;
            addr_q          <= addr_d;
            issued_all_q    <= issued_all_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    assign bus.sub_mult_mem_res_rd_en   = rd_en & (sel_q == SEL_SUB);
    assign bus.add_mult_mem_res_rd_en   = rd_en & (sel_q == SEL_ADD);
    assign bus.sub_mult_mem_res_rd_addr = bus.sub_mult_mem_res_rd_en ? addr_q : '0;
    assign bus.add_mult_mem_res_rd_addr = bus.add_mult_mem_res_rd_en ? addr_q : '0;

    fp2_res_streamer_skid #(
        .RADIX (RADIX),
        .ODD   (ODD)
    ) u_skid (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (inflight_q),
        .in_data_i     ((sel_q == SEL_ADD) ? bus.add_mult_mem_res_dout : bus.sub_mult_mem_res_dout),
        .in_last_i     (inflight_last_q),
        .space_o       (w_space),
        .digit_valid_o (w_valid),
        .digit_ready_i (bus.digit_ready),
        .digit_data_o  (w_data),
        .digit_last_o  (w_last)
    );

    assign bus.digit_valid = w_valid;
    assign bus.digit_data  = w_data;
    assign bus.digit_last  = w_last;

endmodule

`default_nettype wire

// File: doc/fp2_res_streamer.md
Name: fp2_res_streamer

Overview:
- Reads one Fp2 multiplier result memory after `done` and emits its contents as an in-order stream of RADIX-bit digits with valid/ready flow control.
- Selectable memory: sub part or add part. Each memory entry packs two digits (t[2i] in the high half, t[2i+1] in the low half).
- The block replaces bench/host-side unpacking of the packed result memories. It sits between fp2_mont_mul's result read ports and the host/transfer interface.

Parameters:
- RADIX, 32, digit width in bits.
- WIDTH_REAL, 14, number of digits per Fp element.
- WIDTH, ((WIDTH_REAL+1)/2)*2, derived (localparam): padded even digit count.
- RES_MEM_DEPTH, WIDTH/2, derived: result memory entries.
- RES_MEM_DEPTH_LOG, CLOG2(RES_MEM_DEPTH), derived: address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to stream a result; ignored while busy.
- sel  in  1  sampled with start: 0 = sub part memory, 1 = add part memory.
- busy  out  1  high while a stream is in progress.
- done  out  1  one-cycle pulse after the final digit handshake.
- sub_mult_mem_res_rd_en  out  1  read enable, sub memory.
- sub_mult_mem_res_rd_addr  out  RES_MEM_DEPTH_LOG  read address, sub memory.
- sub_mult_mem_res_dout  in  2*RADIX  sub memory data; valid 1 cycle after rd_en.
- add_mult_mem_res_rd_en  out  1  read enable, add memory.
- add_mult_mem_res_rd_addr  out  RES_MEM_DEPTH_LOG  read address, add memory.
- add_mult_mem_res_dout  in  2*RADIX  add memory data; valid 1 cycle after rd_en.
- digit_valid  out  1  stream data valid.
- digit_ready  in  1  stream consumer ready.
- digit_data  out  RADIX  current digit.
- digit_last  out  1  high with the final digit (index WIDTH_REAL-1).

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM in IDLE, counters 0. A reset asserted mid-stream aborts the stream immediately. No done pulse is produced.
- Handshake: a digit transfers on a rising edge with digit_valid & digit_ready.
  - digit_valid never depends combinationally on digit_ready.
  - Once valid is asserted, digit_data and digit_last hold stable until the transfer.
- FSM states: IDLE, FETCH, STREAM, DONE.
  - IDLE: busy=0. start=1 latches sel, clears entry address, then goes to FETCH.
  - FETCH: asserts the selected rd_en with rd_addr=entry address for one cycle. The unselected rd_en stays 0 for the whole stream.
  - STREAM: the dout of the following cycle is captured into a 2*RADIX hold register. The high half is presented first, then the low half.
  - Prefetch: while the high digit is presented, the next entry is read into a one-entry prefetch register. With digit_ready held high, throughput is 1 digit/cycle with no bubbles.
  - After the final digit transfers, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Latency: start sampled at edge 0 → rd_en high in cycle 1 → first digit_valid in cycle 3.
- Digit order: entry i high half = digit 2i, low half = digit 2i+1. Digit count is exactly WIDTH_REAL.
- Odd WIDTH_REAL: the low half of entry RES_MEM_DEPTH-1 is padding. It is never emitted, and digit_last rides on that entry's high half.
- Address never exceeds RES_MEM_DEPTH-1. There is no wrap and no read past the last entry.
- start while busy or in DONE: ignored; sel is not re-latched.
- start in the same cycle as rst deassertion: honoured only on an edge where rst=1.

Decomposition:
- Shared package (fp2 pkg):
  - WIDTH / RES_MEM_DEPTH derivation function.
  - FSM state encoding.
  - SEL_SUB=0 / SEL_ADD=1 constants.
- One sub-module, res_unpack_skid: the hold-plus-prefetch register pair with its valid flags.
  - Takes a 2*RADIX entry in and produces the digit-level valid/ready output plus the last-entry odd-skip flag.
  - Keeps the FSM top free of datapath.

Test Plan:
- WIDTH_REAL=14, sel=0, sub memory entry i = {32'h1000+2i, 32'h1000+2i+1}, digit_ready=1:
  - Digits 0x1000..0x100D stream in order, last on 0x100D.
  - First valid 3 cycles after start; done 1 cycle after the last transfer.
  - Total start→done = 17 cycles.
  - add_mult_mem_res_rd_en stays 0.
- WIDTH_REAL=15, sel=1, add memory entry 7 = {32'hAAAA0000, 32'hDEADBEEF}:
  - Exactly 15 digits, the final one 0xAAAA0000 with last=1.
  - 0xDEADBEEF never appears.
  - rd_addr max = 7.
- Backpressure, WIDTH_REAL=14: digit_ready pseudo-random at 50%.
  - Same 14-digit sequence as the first test.
  - data/last stable whenever valid=1 & ready=0.
  - No digit duplicated or dropped.
- start pulsed in cycle 5 of an active stream with sel flipped:
  - Stream continues from the original memory with the original count.
  - One done pulse only.
- rst driven low after digit 4 transfers, asynchronously between edges:
  - valid/busy/rd_en drop to 0 immediately; no done pulse.
  - A new start after release streams from digit 0.
